sme_wild: RTL and testbench

- Parametrised successor to the string-match engine: buffers a string and a pattern, then searches for the earliest match position.
- Generalises string and pattern depths and character width.
- Adds a single '*' wildcard (zero or more arbitrary chars) and string retention across patterns.
- Adds a busy flag.
- Sits beside the testbench-driven char stream in the univ-cell design; result is reported on a one-cycle valid pulse.

---
 rtl/sme_wild.sv | 277 +++++++++++++++++++++++++++
 tb/tb_sme_wild.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sme_wild.sv
// sme_wild: buffered string / pattern matcher with '^', '$', '.', and a single '*'.
// Characters are loaded in LOAD. SEARCH finds the earliest start index, and DONE
// emits a one-cycle valid strobe with the result.
module sme_wild #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int DW      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DW-1:0]              chardata,
    input  logic                       isstring,
    input  logic                       ispattern,
    output logic                       busy,
    output logic                       valid,
    output logic                       match,
    output logic [$clog2(STR_MAX)-1:0] match_index
);
    localparam int AW = $clog2(STR_MAX);
    localparam int IW = AW + 1;
    localparam int PW = $clog2(PAT_MAX + 1);
    localparam int EW = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int XW = IW + PW + 1;
    localparam logic [IW-1:0] STR_MAX_I = IW'(STR_MAX);
    localparam logic [PW-1:0] PAT_MAX_P = PW'(PAT_MAX);
    localparam logic [XW-1:0] PAT_MAX_X = XW'(PAT_MAX);
    localparam logic [DW-1:0] CH_HEAD   = DW'(8'h5E);
    localparam logic [DW-1:0] CH_TAIL   = DW'(8'h24);
    localparam logic [DW-1:0] CH_STAR   = DW'(8'h2A);
    localparam logic [DW-1:0] CH_ANY    = DW'(8'h2E);
    localparam logic [DW-1:0] CH_SPACE  = DW'(8'h20);
    localparam logic PH_A = 1'b0;  // scan P2 downward for the last qualifying j
    localparam logic PH_B = 1'b1;  // scan P1 upward for the first qualifying i

    typedef enum logic [1:0] {ST_LOAD, ST_SEARCH, ST_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] str_len_q, str_len_d;
    logic          str_prev_q, str_prev_d, pat_prev_q, pat_prev_d, pat_pend_q, pat_pend_d;
    logic [PW-1:0] pat_len_q, pat_len_d, star_pos_q, star_pos_d;
    logic          star_q, star_d, head_q, head_d, tail_q, tail_d;
    logic          dpend_q, dpend_d, dstored_q, dstored_d, phase_q, phase_d;
    logic [IW-1:0] pos_q, pos_d, jmax_q, jmax_d;
    logic          match_q, match_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [DW-1:0] str_q  [STR_MAX];
    logic [DW-1:0] str_d  [STR_MAX];
    logic [DW-1:0] pchr_q [PAT_MAX];
    logic [DW-1:0] pchr_d [PAT_MAX];
    logic          pany_q [PAT_MAX];
    logic          pany_d [PAT_MAX];

    logic [PW-1:0] p1_len, seg_off, seg_len, plen;
    logic [XW-1:0] sidx, eidx, end_pos;
    logic [IW-1:0] prev_pos, wptr;
    logic          seg_all, seg_ok, end_ok, tail_ok, head_ok, a_hit, b_hit, b_last, pstar;

    // Evaluate the current segment (P2 in phase A, P1 in phase B) at scan position pos_q
    always_comb begin
        p1_len = star_q ? star_pos_q : pat_len_q;
        if (phase_q == PH_A) begin
            seg_off = star_pos_q;
            seg_len = pat_len_q - star_pos_q;
        end else begin
            seg_off = '0;
            seg_len = p1_len;
        end
        sidx    = '0;
        eidx    = '0;
        seg_all = 1'b1;
        for (int k = 0; k < PAT_MAX; k++) begin
            sidx = XW'(pos_q) + XW'(k);
            eidx = XW'(seg_off) + XW'(k);
            if (XW'(k) < XW'(seg_len)) begin
                if (sidx >= XW'(str_len_q) || eidx >= PAT_MAX_X) begin
                    seg_all = 1'b0;
                end else if (!pany_q[eidx[EW-1:0]] &&
                             pchr_q[eidx[EW-1:0]] != str_q[sidx[AW-1:0]]) begin
                    seg_all = 1'b0;
                end
            end
        end
        end_pos = XW'(pos_q) + XW'(seg_len);
        end_ok  = 1'b0;
        if (end_pos == XW'(str_len_q)) begin
            end_ok = 1'b1;
        end else if (end_pos < XW'(str_len_q)) begin
            end_ok = (str_q[end_pos[AW-1:0]] == CH_SPACE);
        end
        seg_ok   = seg_all && (end_pos <= XW'(str_len_q));
        tail_ok  = !tail_q || end_ok;
        prev_pos = pos_q - IW'(1);
        head_ok  = 1'b1;
        if (head_q && pos_q != '0) begin
            head_ok = (pos_q <= str_len_q) && (str_q[prev_pos[AW-1:0]] == CH_SPACE);
        end
        a_hit  = seg_ok && tail_ok;
        // With '*', P1 only has to finish at or before the last usable P2 start
        b_hit  = head_ok && seg_ok &&
                 (star_q ? (XW'(pos_q) + XW'(p1_len) <= XW'(jmax_q)) : tail_ok);
        b_last = (XW'(pos_q) + XW'(p1_len) >= XW'(str_len_q)) ||
                 (pos_q >= STR_MAX_I - IW'(1));
    end

    // Next-state logic: character loading, search stepping and result capture
    always_comb begin
        state_d    = state_q;
        str_len_d  = str_len_q;
        str_prev_d = 1'b0;
        pat_prev_d = 1'b0;
        pat_pend_d = pat_pend_q;
        pat_len_d  = pat_len_q;
        star_pos_d = star_pos_q;
        star_d     = star_q;
        head_d     = head_q;
        tail_d     = tail_q;
        dpend_d    = dpend_q;
        dstored_d  = dstored_q;
        phase_d    = phase_q;
        pos_d      = pos_q;
        jmax_d     = jmax_q;
        match_d    = match_q;
        idx_d      = idx_q;
        str_d      = str_q;
        pchr_d     = pchr_q;
        pany_d     = pany_q;
        wptr       = '0;
        plen       = '0;
        pstar      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                str_prev_d = isstring;
                pat_prev_d = ispattern && !isstring;
                if (isstring) begin
                    wptr = str_prev_q ? str_len_q : '0;
                    if (wptr < STR_MAX_I) begin
                        str_d[wptr[AW-1:0]] = chardata;
                        str_len_d = wptr + IW'(1);
                    end else begin
                        str_len_d = wptr;
                    end
                end else if (ispattern) begin
                    pat_pend_d = 1'b1;
                    plen  = pat_prev_q ? pat_len_q : '0;
                    pstar = pat_prev_q && star_q;
                    if (!pat_prev_q) begin
                        pat_len_d  = '0;
                        star_d     = 1'b0;
                        star_pos_d = '0;
                        head_d     = 1'b0;
                        tail_d     = 1'b0;
                        dpend_d    = 1'b0;
                        dstored_d  = 1'b0;
                    end
                    if (!pat_prev_q && chardata == CH_HEAD) begin
                        head_d = 1'b1;
                    end else if (chardata == CH_STAR && !pstar) begin
                        star_d     = 1'b1;
                        star_pos_d = plen;
                        dpend_d    = 1'b0;
                    end else begin
                        // '$' is stored provisionally; it becomes the tail anchor
                        // only if nothing follows it
                        dpend_d   = (chardata == CH_TAIL);
                        dstored_d = (chardata == CH_TAIL) && (plen < PAT_MAX_P);
                        if (plen < PAT_MAX_P) begin
                            pchr_d[plen[EW-1:0]] = chardata;
                            pany_d[plen[EW-1:0]] = (chardata == CH_ANY);
                            pat_len_d = plen + PW'(1);
                        end
                    end
                end else if (pat_pend_q) begin
                    state_d    = ST_SEARCH;
                    pat_pend_d = 1'b0;
                    tail_d     = dpend_q;
                    if (dpend_q && dstored_q) begin
                        pat_len_d = pat_len_q - PW'(1);
                    end
                    dpend_d = 1'b0;
                    phase_d = star_q ? PH_A : PH_B;
                    pos_d   = star_q ? str_len_q : '0;
                end
            end
            ST_SEARCH: begin
                if (pat_len_q == '0) begin
                    state_d = ST_DONE;
                    match_d = 1'b1;
                    idx_d   = '0;
                end else if (phase_q == PH_A) begin
                    if (a_hit) begin
                        jmax_d  = pos_q;
                        phase_d = PH_B;
                        pos_d   = '0;
                    end else if (pos_q == '0) begin
                        state_d = ST_DONE;
                        match_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        pos_d = pos_q - IW'(1);
                    end
                end else begin
                    if (b_hit) begin
                        state_d = ST_DONE;
                        match_d = 1'b1;
                        idx_d   = pos_q[AW-1:0];
                    end else if (b_last) begin
                        state_d = ST_DONE;
                        match_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        pos_d = pos_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Control state and result registers, cleared by the asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            str_len_q  <= '0;
            str_prev_q <= 1'b0;
            pat_prev_q <= 1'b0;
            pat_pend_q <= 1'b0;
            pat_len_q  <= '0;
            star_pos_q <= '0;
            star_q     <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            dpend_q    <= 1'b0;
            dstored_q  <= 1'b0;
            phase_q    <= PH_B;
            pos_q      <= '0;
            jmax_q     <= '0;
            match_q    <= 1'b0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            str_len_q  <= str_len_d;
            str_prev_q <= str_prev_d;
            pat_prev_q <= pat_prev_d;
            pat_pend_q <= pat_pend_d;
            pat_len_q  <= pat_len_d;
            star_pos_q <= star_pos_d;
            star_q     <= star_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            dpend_q    <= dpend_d;
            dstored_q  <= dstored_d;
            phase_q    <= phase_d;
            pos_q      <= pos_d;
            jmax_q     <= jmax_d;
            match_q    <= match_d;
            idx_q      <= idx_d;
        end
    end

    // Character storage; contents are qualified by the lengths, so no reset
    always_ff @(posedge clk) begin
        str_q  <= str_d;
        pchr_q <= pchr_d;
        pany_q <= pany_d;
    end

    assign busy        = (state_q == ST_SEARCH);
    assign valid       = (state_q == ST_DONE);
    assign match       = match_q;
    assign match_index = idx_q;

endmodule

// File: tb/tb_sme_wild.sv
// Testbench for sme_wild: directed loads with a scoreboard-based result monitor.
module tb_sme_wild;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int DW      = 8;
    localparam int AW      = $clog2(STR_MAX);

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] chardata;
    logic          isstring;
    logic          ispattern;
    logic          busy;
    logic          valid;
    logic          match;
    logic [AW-1:0] match_index;

    typedef struct packed {
        logic          m;
        logic [AW-1:0] idx;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    tests = 0;
    int    fails = 0;

    sme_wild #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .chardata   (chardata),
        .isstring   (isstring),
        .ispattern  (ispattern),
        .busy       (busy),
        .valid      (valid),
        .match      (match),
        .match_index(match_index)
    );

    always #5 clk = ~clk;

    // Result monitor: every valid pulse is compared against the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        if (valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got valid=1 match=%0d idx=%0d, required no valid",
                         match, match_index);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests++;
                if (match !== e.m) begin
                    fails++;
                    $display("FAIL %s_match: got %0d, required %0d", nm, match, e.m);
                end
                tests++;
                if (match_index !== e.idx) begin
                    fails++;
                    $display("FAIL %s_idx: got %0d, required %0d", nm, match_index, e.idx);
                end
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL %s_busy_at_valid: got %0d, required 0", nm, busy);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic drive_chars(input string s, input logic as_str);
        for (int i = 0; i < s.len(); i++) begin
            chardata  = s[i];
            isstring  = as_str;
            ispattern = ~as_str;
            @(negedge clk);
        end
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = '0;
    endtask

    task automatic run(input string p, input logic m, input int idx, input string nm);
        exp_t e;
        logic got;
        e.m   = m;
        e.idx = AW'(idx);
        exp_q.push_back(e);
        name_q.push_back(nm);
        drive_chars(p, 1'b0);
        @(negedge clk);
        check({nm, "_busy"}, {31'd0, busy}, 32'd1);
        got = 1'b0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (valid) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no valid in 1000 cycles, required a valid pulse", nm);
            void'(exp_q.pop_back());
            void'(name_q.pop_back());
        end
        @(negedge clk);
    endtask

    task automatic load_overflow();
        for (int i = 0; i < 40; i++) begin
            chardata  = (i < 10) ? 8'h62 : ((i == 35) ? 8'h7A : 8'h61);
            isstring  = 1'b1;
            ispattern = 1'b0;
            @(negedge clk);
        end
        isstring = 1'b0;
        chardata = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        reset     = 1'b1;
        chardata  = '0;
        isstring  = 1'b0;
        ispattern = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_match", {31'd0, match}, 32'd0);
        check("rst_idx",   {27'd0, match_index}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        drive_chars("the cat sat", 1'b1);
        run("c.t",  1'b1, 4, "dot");
        run("^sat", 1'b1, 8, "head");
        run("^at",  1'b0, 0, "retain_head");
        run("at$",  1'b1, 5, "tail");
        run("h*s",  1'b1, 1, "star");
        run("c*x",  1'b0, 0, "star_nomatch");

        drive_chars("aaa bab", 1'b1);
        run("^b.b$", 1'b1, 4, "both_anchors");
        run("^$",    1'b1, 0, "empty");

        load_overflow();
        run("z",          1'b0, 0,  "str_overflow");
        run("aaaaaaaaxy", 1'b1, 10, "pat_overflow");

        // Abort a long star search with reset
        drive_chars("q*q", 1'b0);
        repeat (5) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_match", {31'd0, match}, 32'd0);
        check("abort_idx",   {27'd0, match_index}, 32'd0);
        check("abort_busy",  {31'd0, busy}, 32'd0);
        repeat (100) @(negedge clk);

        drive_chars("the cat sat", 1'b1);
        run("c.t", 1'b1, 4, "after_reset");

        check("leftover_expect", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
